// File: rtl/min_prio_arbiter.sv
// Four-requester minimum-priority-code arbiter with held grants and an ASCII owner report.
// Optional forced-revoke hold timeout is compiled in with `define MINARB_TIMEOUT_EN.
module min_prio_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [2:0] prio_a,
  input  logic [2:0] prio_b,
  input  logic [2:0] prio_c,
  input  logic [2:0] prio_d,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [7:0] gnt_ascii,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("min_prio_arbiter: MAX_HOLD must be in 2..255");
  end

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [3:0] gnt_nxt;
  logic [7:0] ascii_nxt;
  logic [3:0] mask;
  logic       hold_expired;

  logic [2:0] prio [4];
  assign prio[0] = prio_a;
  assign prio[1] = prio_b;
  assign prio[2] = prio_c;
  assign prio[3] = prio_d;

  // A revoked owner is only skipped when someone else is competing.
  logic [3:0] elig;
  logic [1:0] win_idx;
  logic [2:0] win_prio;
  logic       win_found;

  always_comb begin
    elig      = req & ~mask;
    win_idx   = '0;
    win_prio  = '1;
    win_found = 1'b0;
    if (elig == '0) elig = req;
    for (int unsigned i = 0; i < 4; i++) begin
      if (elig[i] && (!win_found || prio[i] < win_prio)) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
        win_prio  = prio[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    gnt_nxt   = gnt;
    ascii_nxt = gnt_ascii;
    case (state)
      IDLE: begin
        if (req != '0) begin
          state_nxt = GRANT;
          owner_nxt = win_idx;
          gnt_nxt   = 4'b0001 << win_idx;
          ascii_nxt = 8'h30 + {6'b0, win_idx};
        end
      end
      GRANT: begin
        if (!req[owner] || hold_expired) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
          ascii_nxt = 8'h2D;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        ascii_nxt = 8'h2D;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_ascii <= 8'h2D;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      gnt_ascii <= ascii_nxt;
    end
  end

`ifdef MINARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       revoke;

  assign hold_expired = (hold_cnt == 8'(MAX_HOLD - 1));
  assign revoke       = (state == GRANT) && req[owner] && hold_expired;

  // Counter sits at zero in IDLE so it is already cleared on GRANT entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      mask     <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= revoke;
      if (state == GRANT) hold_cnt <= hold_cnt + 8'd1;
      else                hold_cnt <= '0;
      if (revoke)
        mask <= gnt;
      else if ((state == IDLE && req != '0) || (state == GRANT && !req[owner]))
        mask <= '0;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign mask         = '0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_min_prio_arbiter.sv
// Self-checking bench for min_prio_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_min_prio_arbiter;

  localparam int unsigned HOLD = 4;
`ifdef MINARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [2:0] prio_a, prio_b, prio_c, prio_d;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [7:0] gnt_ascii;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  min_prio_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .prio_a    (prio_a),
    .prio_b    (prio_b),
    .prio_c    (prio_c),
    .prio_d    (prio_d),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ascii (gnt_ascii),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: phase 0 = idle, 1 = owner holds grant, 2 = dead cycle.
  int         m_phase   = 0;
  int         m_owner   = -1;
  int         m_held    = 0;
  logic [3:0] m_mask    = '0;
  bit         m_timeout = 1'b0;
  bit         started   = 1'b0;

  function automatic int prio_of(input int i);
    case (i)
      0: return int'(prio_a);
      1: return int'(prio_b);
      2: return int'(prio_c);
      default: return int'(prio_d);
    endcase
  endfunction

  function automatic int pick_winner(input logic [3:0] r, input logic [3:0] excl);
    logic [3:0] cand;
    int best;
    cand = r & ~excl;
    if (cand == 4'b0000) cand = r;
    best = -1;
    for (int i = 0; i < 4; i++)
      if (cand[i] && (best < 0 || prio_of(i) < prio_of(best))) best = i;
    return best;
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst_n) begin
      m_phase = 0; m_owner = -1; m_held = 0; m_mask = '0; m_timeout = 1'b0;
    end else begin
      m_timeout = 1'b0;
      if (m_phase == 0) begin
        if (req != 4'b0000) begin
          m_owner = pick_winner(req, m_mask);
          m_phase = 1;
          m_held  = 1;
          m_mask  = '0;
        end
      end else if (m_phase == 1) begin
        if (!req[m_owner]) begin
          m_phase = 2; m_owner = -1; m_mask = '0;
        end else if (TO_EN && m_held == int'(HOLD)) begin
          m_phase = 2; m_mask = 4'b0001 << m_owner; m_owner = -1; m_timeout = 1'b1;
        end else begin
          m_held++;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [3:0] e_gnt;
      logic [7:0] e_ascii;
      e_gnt   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      e_ascii = (m_owner < 0) ? 8'h2D : (8'h30 + 8'(m_owner));
      chk("model_gnt",       {4'b0, gnt},       {4'b0, e_gnt});
      chk("model_gnt_valid", {7'b0, gnt_valid}, {7'b0, (m_owner >= 0)});
      chk("model_gnt_ascii", gnt_ascii,         e_ascii);
      chk("model_timeout",   {7'b0, timeout},   {7'b0, m_timeout});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [3:0] e_gnt, input logic [7:0] e_ascii, input logic e_to);
    chk({name, "_gnt"},     {4'b0, gnt},       {4'b0, e_gnt});
    chk({name, "_ascii"},   gnt_ascii,         e_ascii);
    chk({name, "_valid"},   {7'b0, gnt_valid}, {7'b0, (e_gnt != 4'b0000)});
    chk({name, "_timeout"}, {7'b0, timeout},   {7'b0, e_to});
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b1111;
    prio_a = 3'd0; prio_b = 3'd0; prio_c = 3'd0; prio_d = 3'd0;
    step(2);
    lit("reset", 4'b0000, 8'h2D, 1'b0);

    // Min select with B/D tie, then D after B releases
    rst_n = 1'b1; req = 4'b1111;
    prio_a = 3'd5; prio_b = 3'd3; prio_c = 3'd6; prio_d = 3'd3;
    step(1); lit("minsel_b", 4'b0010, 8'h31, 1'b0);
    req = 4'b1101;
    step(1); lit("minsel_rel", 4'b0000, 8'h2D, 1'b0);
    step(1); lit("minsel_idle", 4'b0000, 8'h2D, 1'b0);
    step(1); lit("minsel_d", 4'b1000, 8'h33, 1'b0);
    req = 4'b0000; step(3);

    // Non-requesters excluded; no preemption during GRANT
    req = 4'b0100; prio_a = 3'd0; prio_b = 3'd0; prio_c = 3'd7; prio_d = 3'd0;
    step(1); lit("excl_c", 4'b0100, 8'h32, 1'b0);
    prio_c = 3'd0; req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step(1); lit("nopreempt", 4'b0100, 8'h32, 1'b0);
    end
    req = 4'b0000; step(3);

    // Mid-grant reset
    req = 4'b0001;
    step(1); lit("mid_a", 4'b0001, 8'h30, 1'b0);
    rst_n = 1'b0;
    step(1); lit("mid_rst", 4'b0000, 8'h2D, 1'b0);
    rst_n = 1'b1;
    step(2); lit("mid_regrant", 4'b0001, 8'h30, 1'b0);
    req = 4'b0000; step(3);

`ifdef MINARB_TIMEOUT_EN
    req = 4'b0011; prio_a = 3'd1; prio_b = 3'd2; prio_c = 3'd0; prio_d = 3'd0;
    for (int i = 0; i < int'(HOLD); i++) begin
      step(1); lit("to_hold_a", 4'b0001, 8'h30, 1'b0);
    end
    step(1); lit("to_revoke", 4'b0000, 8'h2D, 1'b1);
    step(1); lit("to_idle", 4'b0000, 8'h2D, 1'b0);
    step(1); lit("to_next_b", 4'b0010, 8'h31, 1'b0);
    req = 4'b0000; step(3);

    req = 4'b0001;
    for (int i = 0; i < int'(HOLD); i++) begin
      step(1); lit("sole_hold", 4'b0001, 8'h30, 1'b0);
    end
    step(1); lit("sole_revoke", 4'b0000, 8'h2D, 1'b1);
    step(1); lit("sole_idle", 4'b0000, 8'h2D, 1'b0);
    step(1); lit("sole_regrant", 4'b0001, 8'h30, 1'b0);
    req = 4'b0000; step(3);
`else
    req = 4'b0001;
    step(1);
    for (int i = 0; i < 100; i++) begin
      chk("hold_forever", {3'b0, timeout, gnt}, 8'h01);
      step(1);
    end
    req = 4'b0000; step(3);
`endif

    // Randomized traffic; the per-cycle model compare does the checking
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      prio_a = 3'($urandom_range(0, 7));
      prio_b = 3'($urandom_range(0, 7));
      prio_c = 3'($urandom_range(0, 7));
      prio_d = 3'($urandom_range(0, 7));
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/min_prio_arbiter.md
# min_prio_arbiter

Four-requester arbiter sharing a single resource using the team's minimum-value selection rule: among active requesters, the one with the smallest 3-bit priority code wins, and ties go to the lowest index (A before B before C before D). The grant is held until the owner releases it. The winner is also reported as an ASCII digit ('0'–'3') for the LCD/UART display path. An optional hold timeout revokes a grant that is held too long.

## Interface
- `MAX_HOLD`, default 15: maximum number of GRANT cycles before forced revoke. Legal range 2–255. Used only when `MINARB_TIMEOUT_EN` is defined.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `req` input 4: request lines; bit0=A, bit1=B, bit2=C, bit3=D; level-sensitive.
- `prio_a`, `prio_b`, `prio_c`, `prio_d` input 3 each: priority codes; a lower value means higher priority.
- `gnt` output 4: one-hot grant, registered.
- `gnt_valid` output 1: high while any `gnt` bit is high.
- `gnt_ascii` output 8: ASCII index of the current owner, 0x30–0x33; 0x2D ('-') when there is no owner.
- `timeout` output 1: one-cycle pulse on forced revoke; constant 0 when the timeout feature is compiled out.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- **IDLE**
  - If `req` is nonzero, compute the winner among the set bits only. Non-requesting channels are excluded regardless of their priority code.
  - Winner rule: smallest `prio_x`; on a tie, the lowest index.
  - Next cycle: state GRANT, `gnt` = one-hot winner, `gnt_valid` = 1, `gnt_ascii` = 0x30 + index.
  - If `req` is zero, stay in IDLE with all outputs at idle values.
- **GRANT**
  - Only `req[owner]` is observed. Other req bits and all prio inputs are ignored; there is no preemption.
  - When `req[owner]` is sampled 0, next cycle: state RELEASE, `gnt` = 0, `gnt_valid` = 0, `gnt_ascii` = 0x2D.
- **RELEASE**
  - One dead cycle. No arbitration is performed; the next state is always IDLE.
- Priority codes are sampled only in the IDLE arbitration cycle.
- Reset values: state IDLE, `gnt` = 4'b0000, `gnt_valid` = 0, `gnt_ascii` = 8'h2D, `timeout` = 0, hold counter 0, revoke mask 4'b0000.
- Reset has priority over every transition. Asserting `rst_n` = 0 mid-grant drops `gnt` on the next edge.

## Timing
- Arbitration latency: `req` sampled at edge N produces `gnt` at edge N+1.
- Release: `req[owner]` = 0 sampled at edge M drops `gnt` at edge M+1 and enters RELEASE.
  - IDLE at M+2.
  - The earliest next grant appears at edge M+3.
- Back-to-back minimum: 1 dead cycle (RELEASE) plus 1 arbitration cycle (IDLE) between grants.
- A requester that drops and reasserts `req` while still in GRANT is not seen. It is treated as held only if `req` is high at every sampled edge; a single low sample releases.
- Each winner must hold `req` high until it sees `gnt`. A requester that drops `req` in the cycle its grant appears is released on the following edge.

## Configuration
- Macro: `MINARB_TIMEOUT_EN`.
- **Defined**
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches `MAX_HOLD`-1 with `req[owner]` still 1, the FSM goes to RELEASE as for a normal release, and `timeout` pulses for 1 cycle, coincident with `gnt` falling.
  - The revoked index is loaded into the revoke mask. It is excluded from the next IDLE arbitration only if another requester is active; if it is the sole requester, it may win again.
  - The mask clears after that arbitration, and on a normal release.
- **Undefined**
  - No counter or mask logic.
  - A grant is held indefinitely while `req[owner]` = 1.
  - `timeout` is tied to 0.
  - `MAX_HOLD` is ignored.

## Test plan
- Reset: `rst_n` = 0 for 2 edges with `req` = 4'b1111 -> `gnt` = 0, `gnt_valid` = 0, `gnt_ascii` = 0x2D, `timeout` = 0.
- Min select: `req` = 1111, prio a..d = 5,3,6,3 -> next edge `gnt` = 0010, `gnt_ascii` = 0x31 (the B/D tie goes to B). Then B drops -> `gnt` = 0 for 2 cycles, then D is granted: `gnt` = 1000, 0x33.
- Exclusion: `req` = 0100, prio a..d = 0,0,7,0 -> `gnt` = 0100, 0x32. Changing `prio_c` to 0 and raising `req[0]` during GRANT -> no change to `gnt`.
- Mid-grant reset: A is granted, then `rst_n` = 0 for one edge -> `gnt` = 0 and 0x2D on that edge. With `req` still 0001 after reset -> `gnt` = 0001 two edges later.
- Timeout (macro defined, `MAX_HOLD` = 4): A holds `req`, B requests -> `gnt` = 0001 for 4 cycles, then `timeout` pulses with `gnt` = 0 -> next grant goes to B (0010) even though A has the lower code.
- Timeout sole requester (macro defined): only A is requesting -> revoke, then A is regranted (0001). With the macro undefined, the same stimulus keeps `gnt` = 0001 for 100 cycles with `timeout` = 0.
